// File: rtl/alu_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : alu_arbiter_if
//  Purpose  : Bundles the two requester channels and the response channel
//             of the shared-ALU arbiter.
//  Ports    : req0_*/req1_* : valid/ready request channels (op, a, b)
//             rsp_*         : valid/ready response channel
//                             (id, result, flags {N,Z,C,V}, err)
//  Modports : slave  - arbiter side
//             master - requester/consumer side
//  Revision : 1.0  initial release
// ============================================================================
interface alu_arbiter_if #(
    parameter int DATA_W = 32
);
    logic              req0_valid;
    logic              req0_ready;
    logic [3:0]        req0_op;
    logic [DATA_W-1:0] req0_a;
    logic [DATA_W-1:0] req0_b;

    logic              req1_valid;
    logic              req1_ready;
    logic [3:0]        req1_op;
    logic [DATA_W-1:0] req1_a;
    logic [DATA_W-1:0] req1_b;

    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_id;
    logic [DATA_W-1:0] rsp_result;
    logic [3:0]        rsp_flags;
    logic              rsp_err;

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        output req0_ready,
        input  req1_valid, req1_op, req1_a, req1_b,
        output req1_ready,
        input  rsp_ready,
        output rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_err
    );

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        input  req0_ready,
        output req1_valid, req1_op, req1_a, req1_b,
        input  req1_ready,
        output rsp_ready,
        input  rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_err
    );
endinterface
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : alu_arbiter
//  Purpose  : Shares one ADD/SUB/AND/ORR ALU between two requesters.
//             Round-robin grant in IDLE, one EXEC cycle, then the
//             registered response is held in RESP until taken.
//  Ports    : clk   - rising-edge clock
//             reset - synchronous, active-high reset
//             bus   - alu_arbiter_if.slave (request and response channels)
//  Revision : 1.0  initial release
// ============================================================================
module alu_arbiter #(
    parameter int DATA_W = 32
) (
    input  logic           clk,
    input  logic           reset,
    alu_arbiter_if.slave   bus
);
    localparam int         c_MSB     = DATA_W - 1;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_EXEC = 2'd1;
    localparam logic [1:0] c_ST_RESP = 2'd2;

    localparam logic [3:0] c_OP_ADD  = 4'b0100;
    localparam logic [3:0] c_OP_SUB  = 4'b0010;
    localparam logic [3:0] c_OP_AND  = 4'b0000;
    localparam logic [3:0] c_OP_ORR  = 4'b1100;

    logic [1:0]        r_state;
    logic              r_prio;      // requester favoured on a tie
    logic [3:0]        r_op;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic              r_id;

    logic              r_rsp_valid;
    logic              r_rsp_id;
    logic [DATA_W-1:0] r_rsp_result;
    logic [3:0]        r_rsp_flags;
    logic              r_rsp_err;

    logic              w_idle;
    logic              w_grant0;
    logic              w_grant1;
    logic              w_ready0;
    logic              w_ready1;
    logic              w_accept;

    logic [DATA_W:0]   w_sum;
    logic [DATA_W-1:0] w_result;
    logic              w_c;
    logic              w_v;
    logic              w_err;
    logic [3:0]        w_flags;

    // ------------------------------------------------------------------
    // Arbitration: only one grant can be true at a time because a tie is
    // resolved by r_prio. Ready is masked during reset so nothing is
    // accepted on the reset edge.
    // ------------------------------------------------------------------
    assign w_idle   = (r_state == c_ST_IDLE) && !reset;
    assign w_grant0 = bus.req0_valid && (!bus.req1_valid || !r_prio);
    assign w_grant1 = bus.req1_valid && (!bus.req0_valid ||  r_prio);
    assign w_ready0 = w_idle && w_grant0;
    assign w_ready1 = w_idle && w_grant1;
    assign w_accept = w_ready0 || w_ready1;

    assign bus.req0_ready = w_ready0;
    assign bus.req1_ready = w_ready1;

    // ------------------------------------------------------------------
    // ALU, fed only from the captured operands. SUB is A + ~B + 1 so the
    // carry out is the ARM-style "no borrow".
    // ------------------------------------------------------------------
    always_comb begin
        w_sum    = '0;
        w_result = '0;
        w_c      = 1'b0;
        w_v      = 1'b0;
        w_err    = 1'b0;
        case (r_op)
            c_OP_ADD: begin
                w_sum    = {1'b0, r_a} + {1'b0, r_b};
                w_result = w_sum[c_MSB:0];
                w_c      = w_sum[DATA_W];
                w_v      = (r_a[c_MSB] == r_b[c_MSB]) && (w_result[c_MSB] != r_a[c_MSB]);
            end
            c_OP_SUB: begin
                w_sum    = {1'b0, r_a} + {1'b0, ~r_b} + (DATA_W+1)'(1);
                w_result = w_sum[c_MSB:0];
                w_c      = w_sum[DATA_W];
                w_v      = (r_a[c_MSB] != r_b[c_MSB]) && (w_result[c_MSB] != r_a[c_MSB]);
            end
            c_OP_AND: w_result = r_a & r_b;
            c_OP_ORR: w_result = r_a | r_b;
            default:  w_err    = 1'b1;
        endcase
    end

    // An unsupported op reports a zero result, hence Z set and all else clear.
    assign w_flags = w_err ? 4'b0100
                           : {w_result[c_MSB], (w_result == '0), w_c, w_v};

    // ------------------------------------------------------------------
    // Control FSM and registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_ST_IDLE;
            r_prio       <= 1'b0;
            r_op         <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_id         <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_flags  <= '0;
            r_rsp_err    <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_accept) begin
                        r_state <= c_ST_EXEC;
                        r_id    <= w_ready1;
                        r_op    <= w_ready1 ? bus.req1_op : bus.req0_op;
                        r_a     <= w_ready1 ? bus.req1_a  : bus.req0_a;
                        r_b     <= w_ready1 ? bus.req1_b  : bus.req0_b;
                        // Favour the requester that was not just served.
                        r_prio  <= ~w_ready1;
                    end
                end
                c_ST_EXEC: begin
                    r_state      <= c_ST_RESP;
                    r_rsp_valid  <= 1'b1;
                    r_rsp_id     <= r_id;
                    r_rsp_result <= w_err ? '0 : w_result;
                    r_rsp_flags  <= w_flags;
                    r_rsp_err    <= w_err;
                end
                c_ST_RESP: begin
                    if (bus.rsp_ready) begin
                        r_state     <= c_ST_IDLE;
                        r_rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= c_ST_IDLE;
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_id     = r_rsp_id;
    assign bus.rsp_result = r_rsp_result;
    assign bus.rsp_flags  = r_rsp_flags;
    assign bus.rsp_err    = r_rsp_err;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_arbiter
//  Purpose  : Self-checking bench for alu_arbiter. Accepted requests push
//             a modelled response into a scoreboard queue; responses taken
//             from the DUT are popped and compared.
//  Ports    : none (top-level bench)
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_arbiter;

    typedef struct packed {
        logic        id;
        logic [31:0] result;
        logic [3:0]  flags;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    alu_arbiter_if #(.DATA_W(32)) bus ();

    alu_arbiter #(.DATA_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int   n_pass  = 0;
    int   n_total = 0;
    exp_t scb[$];
    int   grants[$];
    int   cyc     = 0;
    int   acc_cyc = -100;
    int   rem0    = 0;
    int   rem1    = 0;

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Reference: wide signed/unsigned arithmetic for carry and overflow.
    function automatic exp_t model(logic id, logic [3:0] op, logic [31:0] a, logic [31:0] b);
        exp_t   e;
        longint sa, sbv;
        logic   c, v;
        e.id = id; e.err = 1'b0; c = 1'b0; v = 1'b0;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        case (op)
            4'b0100: begin
                e.result = a + b;
                c = (64'(a) + 64'(b)) > 64'h0000_0000_FFFF_FFFF;
                v = (sa + sbv) != longint'($signed(e.result));
            end
            4'b0010: begin
                e.result = a - b;
                c = (a >= b);
                v = (sa - sbv) != longint'($signed(e.result));
            end
            4'b0000: e.result = a & b;
            4'b1100: e.result = a | b;
            default: begin e.result = 32'h0; e.err = 1'b1; end
        endcase
        e.flags = e.err ? 4'b0100 : {e.result[31], (e.result == 32'h0), c, v};
        return e;
    endfunction

    // One clock: observe handshakes for the coming edge, then advance to
    // the next falling edge and update requester payloads.
    task automatic tick();
        exp_t e;
        logic acc0, acc1;
        #1;
        check("ready_excl", {63'd0, bus.req0_ready && bus.req1_ready}, 64'd0);
        if (cyc == acc_cyc + 1) check("lat_exec_valid", {63'd0, bus.rsp_valid}, 64'd0);
        if (cyc == acc_cyc + 2) check("lat_resp_valid", {63'd0, bus.rsp_valid}, 64'd1);
        if (!reset && bus.rsp_valid && bus.rsp_ready) begin
            check("scb_nonempty", {63'd0, scb.size() != 0}, 64'd1);
            if (scb.size() != 0) begin
                e = scb.pop_front();
                check("rsp_id",     {63'd0, bus.rsp_id},    {63'd0, e.id});
                check("rsp_result", {32'd0, bus.rsp_result}, {32'd0, e.result});
                check("rsp_flags",  {60'd0, bus.rsp_flags},  {60'd0, e.flags});
                check("rsp_err",    {63'd0, bus.rsp_err},    {63'd0, e.err});
            end
        end
        acc0 = bus.req0_valid && bus.req0_ready;
        acc1 = bus.req1_valid && bus.req1_ready;
        if (acc0) begin
            scb.push_back(model(1'b0, bus.req0_op, bus.req0_a, bus.req0_b));
            grants.push_back(0);
            acc_cyc = cyc;
        end
        if (acc1) begin
            scb.push_back(model(1'b1, bus.req1_op, bus.req1_a, bus.req1_b));
            grants.push_back(1);
            acc_cyc = cyc;
        end
        @(negedge clk);
        cyc++;
        if (acc0) begin
            rem0--;
            if (rem0 > 0) begin
                bus.req0_a = bus.req0_a + 32'h1000_0001;
                bus.req0_b = bus.req0_b ^ 32'h0F0F_0F0F;
            end else bus.req0_valid = 1'b0;
        end
        if (acc1) begin
            rem1--;
            if (rem1 > 0) begin
                bus.req1_a = bus.req1_a + 32'h0300_0007;
                bus.req1_b = bus.req1_b ^ 32'hA5A5_0000;
            end else bus.req1_valid = 1'b0;
        end
    endtask

    task automatic issue(logic id, logic [3:0] op, logic [31:0] a, logic [31:0] b);
        if (id) begin
            bus.req1_op = op; bus.req1_a = a; bus.req1_b = b; bus.req1_valid = 1'b1; rem1 = 1;
        end else begin
            bus.req0_op = op; bus.req0_a = a; bus.req0_b = b; bus.req0_valid = 1'b1; rem0 = 1;
        end
    endtask

    task automatic wait_rsp(int budget);
        int n = 0;
        while (!bus.rsp_valid && n < budget) begin tick(); n++; end
        check("rsp_timeout", {63'd0, bus.rsp_valid}, 64'd1);
    endtask

    task automatic wait_drain(int budget);
        int n = 0;
        while ((scb.size() != 0 || bus.req0_valid || bus.req1_valid) && n < budget) begin
            tick(); n++;
        end
        check("drain_timeout", 64'(scb.size()), 64'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        rem0 = 0; rem1 = 0;
        scb.delete();
        acc_cyc = -100;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        bus.req0_valid = 1'b0; bus.req0_op = 4'h0; bus.req0_a = '0; bus.req0_b = '0;
        bus.req1_valid = 1'b0; bus.req1_op = 4'h0; bus.req1_a = '0; bus.req1_b = '0;
        bus.rsp_ready  = 1'b1;
        tick(); tick(); tick();

        // Reset state
        check("rst_rsp_valid",  {63'd0, bus.rsp_valid},  64'd0);
        check("rst_rsp_id",     {63'd0, bus.rsp_id},     64'd0);
        check("rst_rsp_result", {32'd0, bus.rsp_result}, 64'd0);
        check("rst_rsp_flags",  {60'd0, bus.rsp_flags},  64'd0);
        check("rst_rsp_err",    {63'd0, bus.rsp_err},    64'd0);
        bus.req0_valid = 1'b1;
        #1;
        check("rst_ready0_low", {63'd0, bus.req0_ready}, 64'd0);
        bus.req0_valid = 1'b0;
        reset = 1'b0;
        tick();

        // Unsigned wrap of ADD
        issue(1'b0, 4'b0100, 32'hFFFF_FFFF, 32'h0000_0001);
        tick();
        wait_rsp(5);
        check("ovf_result", {32'd0, bus.rsp_result}, 64'h0);
        check("ovf_flags",  {60'd0, bus.rsp_flags},  64'b0110);
        check("ovf_id",     {63'd0, bus.rsp_id},     64'd0);
        wait_drain(10);

        // SUB borrow, then SUB signed overflow
        issue(1'b1, 4'b0010, 32'h0000_0005, 32'h0000_0007);
        tick();
        wait_rsp(5);
        check("sub1_result", {32'd0, bus.rsp_result}, 64'hFFFF_FFFE);
        check("sub1_flags",  {60'd0, bus.rsp_flags},  64'b1000);
        check("sub1_id",     {63'd0, bus.rsp_id},     64'd1);
        wait_drain(10);
        issue(1'b1, 4'b0010, 32'h8000_0000, 32'h0000_0001);
        tick();
        wait_rsp(5);
        check("sub2_result", {32'd0, bus.rsp_result}, 64'h7FFF_FFFF);
        check("sub2_flags",  {60'd0, bus.rsp_flags},  64'b0011);
        wait_drain(10);

        // Round-robin with both requesters continuously valid
        do_reset();
        grants.delete();
        bus.req0_op = 4'b0100; bus.req0_a = 32'h7FFF_FFF0; bus.req0_b = 32'h0000_0020;
        bus.req1_op = 4'b1100; bus.req1_a = 32'h1234_0000; bus.req1_b = 32'h0000_5678;
        bus.req0_valid = 1'b1; bus.req1_valid = 1'b1; rem0 = 2; rem1 = 2;
        wait_drain(60);
        check("rr_count", 64'(grants.size()), 64'd4);
        if (grants.size() == 4) begin
            check("rr_g0", 64'(grants[0]), 64'd0);
            check("rr_g1", 64'(grants[1]), 64'd1);
            check("rr_g2", 64'(grants[2]), 64'd0);
            check("rr_g3", 64'(grants[3]), 64'd1);
        end

        // Backpressure: response held, no acceptance in RESP
        bus.rsp_ready = 1'b0;
        issue(1'b0, 4'b1100, 32'h0F0F_0000, 32'h0000_00F0);
        tick();
        wait_rsp(5);
        issue(1'b1, 4'b0100, 32'h0000_0010, 32'h0000_0020);
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_valid",  {63'd0, bus.rsp_valid},  64'd1);
            check("bp_result", {32'd0, bus.rsp_result}, 64'h0F0F_00F0);
            check("bp_flags",  {60'd0, bus.rsp_flags},  64'b0000);
            check("bp_id",     {63'd0, bus.rsp_id},     64'd0);
            check("bp_ready0", {63'd0, bus.req0_ready}, 64'd0);
            check("bp_ready1", {63'd0, bus.req1_ready}, 64'd0);
            tick();
        end
        bus.rsp_ready = 1'b1;
        tick();
        #1;
        check("bp_back_idle", {63'd0, bus.req1_ready}, 64'd1);
        wait_drain(10);

        // Unsupported opcode, then AND
        issue(1'b0, 4'b1111, 32'h1234_5678, 32'h0000_0001);
        tick();
        wait_rsp(5);
        check("bad_err",    {63'd0, bus.rsp_err},    64'd1);
        check("bad_result", {32'd0, bus.rsp_result}, 64'h0);
        check("bad_flags",  {60'd0, bus.rsp_flags},  64'b0100);
        wait_drain(10);
        issue(1'b0, 4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00);
        tick();
        wait_rsp(5);
        check("and_result", {32'd0, bus.rsp_result}, 64'hF000_F000);
        check("and_flags",  {60'd0, bus.rsp_flags},  64'b1000);
        check("and_err",    {63'd0, bus.rsp_err},    64'd0);
        wait_drain(10);

        // Reset while in EXEC: operation discarded, prio back to requester 0
        issue(1'b1, 4'b0100, 32'h0000_0001, 32'h0000_0002);
        tick();
        reset = 1'b1;
        scb.delete();
        acc_cyc = -100;
        tick();
        check("mid_rsp_valid",  {63'd0, bus.rsp_valid},  64'd0);
        check("mid_rsp_id",     {63'd0, bus.rsp_id},     64'd0);
        check("mid_rsp_result", {32'd0, bus.rsp_result}, 64'h0);
        check("mid_rsp_flags",  {60'd0, bus.rsp_flags},  64'd0);
        check("mid_rsp_err",    {63'd0, bus.rsp_err},    64'd0);
        reset = 1'b0;
        tick();
        tick();
        check("mid_no_rsp", {63'd0, bus.rsp_valid}, 64'd0);
        grants.delete();
        issue(1'b0, 4'b0100, 32'h0000_0003, 32'h0000_0004);
        issue(1'b1, 4'b0010, 32'h0000_0009, 32'h0000_0004);
        #1;
        check("mid_grant0", {63'd0, bus.req0_ready}, 64'd1);
        check("mid_grant1", {63'd0, bus.req1_ready}, 64'd0);
        wait_drain(30);
        check("mid_order_n", 64'(grants.size()), 64'd2);
        if (grants.size() == 2) begin
            check("mid_order0", 64'(grants[0]), 64'd0);
            check("mid_order1", 64'(grants[1]), 64'd1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
